hex_display_sequencer: RTL
==========================

Name: hex_display_sequencer

Overview:
Time-shares one combinational hex-to-seven-segment decoder across NUM_DIGITS display digits (HEX0..HEX5 on DE1-SoC).
- A requester loads a packed nibble word through a valid/ready handshake.
- The block scans one digit per cycle through the shared decoder into staging registers, then commits all digits atomically.
- Outputs are registered, active-low segment vectors that drive the board pins directly.

Parameters:
NUM_DIGITS, 6, number of display digits scanned and driven
SCROLL_PERIOD, 50000000, clock cycles between scroll rotations (used only with HEX_SCROLL_EN)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
load_valid  input  1  requester has a new display word
load_ready  output  1  block can accept a word this cycle
load_data  input  4*NUM_DIGITS  digit i nibble = load_data[4i+:4]
blank_mask  input  NUM_DIGITS  bit i set: digit i is blanked (all segments off); captured with load_data
hex_out  output  7*NUM_DIGITS  digit i segments = hex_out[7i+:7]; active-low; bit0 = top segment, clockwise, bit6 = middle
busy  output  1  high while in SCAN or COMMIT
done  output  1  one-cycle pulse after commit
scroll_en  input  1  present only with HEX_SCROLL_EN; enables rotation

Behaviour:
- Reset (synchronous, any state):
  - hex_out = 7'h7F in every digit; staging registers = 7'h7F.
  - state = IDLE; load_ready = 1; busy = 0; done = 0; digit index = 0.
- Reset mid-SCAN or mid-COMMIT aborts the update, produces no done pulse, and leaves outputs blanked.
- States: IDLE, SCAN, COMMIT.
- IDLE:
  - load_ready = 1.
  - Transfer occurs when load_valid & load_ready at edge E0: capture load_data and blank_mask into shadow registers, set idx = 0, go to SCAN.
- SCAN:
  - load_ready = 0; busy = 1.
  - Each cycle the decoder input is shadow nibble[idx].
  - At the next edge, staging[idx] <= blank[idx] ? 7'h7F : decode(nibble); idx++.
  - At idx == NUM_DIGITS-1, go to COMMIT.
  - Staging digit i is written at edge E0+1+i.
- COMMIT:
  - At edge E0+NUM_DIGITS+1: hex_out <= staging (all digits at once, no tearing); done registered high for the following cycle; state goes to IDLE.
  - load_ready returns high in that same cycle, so a back-to-back accept is possible at edge E0+NUM_DIGITS+2.
- Latency: NUM_DIGITS+1 edges from accept to visible output. Maximum throughput is one word per NUM_DIGITS+2 cycles.
- load_valid while not ready: ignored; requester holds valid and data until the transfer. Data changes while not ready are don't-care.
- idx width = $clog2(NUM_DIGITS); idx resets to 0 at each accept, so there is no wrap in normal operation.
- Decode table (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

Optional Feature:
HEX_SCROLL_EN.
- Defined: scroll_en port and a scroll counter (width $clog2(SCROLL_PERIOD)) exist.
  - In IDLE with scroll_en = 1, the counter increments each cycle.
  - When it reaches SCROLL_PERIOD-1, it clears and hex_out rotates one digit toward higher index: digit i <= digit i-1, digit 0 <= digit NUM_DIGITS-1.
  - The counter clears on accept, on reset, and whenever scroll_en = 0.
  - No rotation occurs during SCAN or COMMIT.
  - A commit overwrites any rotated state.
- Undefined: no scroll_en port, no counter; hex_out changes only on commit and reset.

Decomposition:
- Package hex_disp_pkg:
  - state enum {IDLE, SCAN, COMMIT}
  - SEG_BLANK = 7'h7F
  - 16-entry decode constant table
- Sub-module seg7_decode: combinational 4-bit to 7-bit active-low decoder using the package table. Instantiated exactly once (the shared resource).

Test Plan:
- Reset held 2 cycles -> hex_out = 42'h3FF_FFFF_FFFF, load_ready = 1, busy = 0, done = 0.
- Load 24'h012345 with mask 0 accepted at edge E0 -> hex_out unchanged through E0+6. At E0+7, digits 0..5 = 12, 19, 30, 24, 79, 40; done high exactly one cycle; load_ready = 1.
- Hold load_valid with 24'hFFFFFF during busy -> not accepted until load_ready = 1. Then accepted; after commit all digits = 0E.
- Load 24'hABCDEF with mask 6'b100001 -> digits 0 and 5 = 7F; digits 1..4 = 06, 21, 46, 03.
- Assert reset when idx = 3 in SCAN -> all digits 7F at next edge; no done pulse; IDLE with load_ready = 1.
- HEX_SCROLL_EN, SCROLL_PERIOD = 4: commit 24'h012345, then scroll_en = 1 -> every 4 cycles the digits rotate up one position. After 6 rotations the original pattern returns. scroll_en = 0 freezes the display.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the hex display sequencer.
// Holds the sequencer state encoding, the blank segment pattern and the
// active-low hex-to-seven-segment table (bit0 = top, clockwise, bit6 = middle).
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns indexed by nibble value 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_display_sequencer_seg7_decode.sv
// Combinational 4-bit to active-low 7-segment decoder.
// Instantiated once by the sequencer and shared across all digits.
module seg7_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; every path assigns seg so no storage is implied.
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/hex_display_sequencer.sv
// Hex display sequencer: accepts a packed nibble word via valid/ready,
// scans one digit per cycle through a single shared decoder into staging
// registers, then commits all digits to the registered outputs at once.
// Optional feature macro: HEX_SCROLL_EN adds the scroll_en port and a
// rotation of the committed display every SCROLL_PERIOD idle cycles.
module hex_display_sequencer
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6
`ifdef HEX_SCROLL_EN
    , parameter int SCROLL_PERIOD = 50000000
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    done
`ifdef HEX_SCROLL_EN
    , input  logic                  scroll_en
`endif
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

`ifdef HEX_SCROLL_EN
    localparam int CNT_W = (SCROLL_PERIOD > 1) ? $clog2(SCROLL_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCROLL_PERIOD - 1);
    logic [CNT_W-1:0] scroll_cnt;
`endif

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [3:0]             shadow_nib   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]  shadow_blank;
    logic [6:0]             staging      [NUM_DIGITS];
    logic [6:0]             disp         [NUM_DIGITS];
    logic [3:0]             dec_in;
    logic [6:0]             dec_seg;

    // Select the shadow nibble currently being scanned for the shared decoder.
    always_comb begin
        dec_in = shadow_nib[idx];
    end

    seg7_decode u_decode (
        .nibble (dec_in),
        .seg    (dec_seg)
    );

    // Sequencer FSM: accept, per-digit scan into staging, atomic commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            load_ready   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            // NOTE: staging and display arrays are reset because a reset must
            // leave the panel blank; the shadow word is not, since it is only
            // read after an accept has overwritten it.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                staging[i] <= SEG_BLANK;
                disp[i]    <= SEG_BLANK;
            end
`ifdef HEX_SCROLL_EN
            scroll_cnt   <= '0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register here samples pre-edge values regardless of order.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid && load_ready) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            shadow_nib[i] <= load_data[4*i +: 4];
                        end
                        shadow_blank <= blank_mask;
                        idx          <= '0;
                        load_ready   <= 1'b0;
                        busy         <= 1'b1;
                        state        <= SCAN;
`ifdef HEX_SCROLL_EN
                        scroll_cnt   <= '0;
`endif
                    end
`ifdef HEX_SCROLL_EN
                    else if (!scroll_en) begin
                        scroll_cnt <= '0;
                    end else if (scroll_cnt == CNT_LAST) begin
                        scroll_cnt <= '0;
                        disp[0]    <= disp[NUM_DIGITS-1];
                        for (int i = 1; i < NUM_DIGITS; i++) begin
                            disp[i] <= disp[i-1];
                        end
                    end else begin
                        scroll_cnt <= scroll_cnt + 1'b1;
                    end
`endif
                end
                SCAN: begin
                    staging[idx] <= shadow_blank[idx] ? SEG_BLANK : dec_seg;
                    idx          <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        disp[i] <= staging[i];
                    end
                    done       <= 1'b1;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the committed display registers onto the pin vector.
    always_comb begin
        // NOTE: hex_out gets a full default first so no path can leave bits
        // unassigned and infer a latch.
        hex_out = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_out[7*i +: 7] = disp[i];
        end
    end

endmodule
